lut_ram_loader: RTL and testbench
=================================

Name: lut_ram_loader

Overview:
Initiator/writer side of the lut_ram interface. Accepts a stream of words over a valid/ready handshake and writes them into consecutive lut_ram addresses starting at a programmable base. Each word is read back on the cycle after its write and compared; the block reports completion and the first mismatch. Used for table preload at boot and in benches that populate lut_ram.

Parameters:
LUT_WIDTH, 32, data word width in bits; matches lut_ram.
LUT_DEPTH, 256, number of lut_ram entries; power of two.
AW, $clog2(LUT_DEPTH), address width (derived; not overridden).

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  reset; active-low, asynchronous assert.
start  in  1  one-cycle pulse; begins a load. Ignored unless busy=0.
abort  in  1  cancels the current load; returns to IDLE.
base_addr  in  AW  first write address; sampled on start.
count  in  AW+1  number of words, 0..LUT_DEPTH; sampled on start.
in_valid  in  1  in_data holds a word.
in_ready  out  1  loader accepts a word this cycle.
in_data  in  LUT_WIDTH  word to write.
wr_en  out  1  lut_ram write enable.
wr_addr  out  AW  lut_ram write address.
wr_data  out  LUT_WIDTH  lut_ram write data.
rd_addr  out  AW  lut_ram read address for readback.
rd_data  in  LUT_WIDTH  lut_ram combinational read data.
busy  out  1  high in LOAD and VERIFY.
done  out  1  one-cycle pulse when a load completes.
error  out  1  sticky mismatch flag; cleared on accepted start.
err_addr  out  AW  address of the first mismatch; valid while error=1.

Behaviour:
- Reset values: state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, done=0, error=0, err_addr=0; internal counters 0.
- FSM states are IDLE, LOAD and VERIFY.
- IDLE: on start with count>0, latch base_addr into addr_q and count into remaining; clear error and err_addr; go to LOAD. On start with count=0, pulse done next cycle and stay IDLE.
- LOAD: in_ready=1. A transfer occurs when in_valid&&in_ready. Write is combinational pass-through in the transfer cycle: wr_en=1, wr_addr=addr_q, wr_data=in_data.
- Each transfer registers (addr_q, in_data) into the verify stage, sets vld_q=1, increments addr_q modulo LUT_DEPTH (wraps from LUT_DEPTH-1 to 0) and decrements remaining.
- When the transfer with remaining=1 occurs, go to VERIFY.
- Verify stage, cycle after a write: rd_addr=vaddr_q; compare rd_data to vdata_q when vld_q=1. vld_q clears if no transfer occurs that cycle.
- On the first mismatch while error=0: set error=1 and err_addr=vaddr_q. Later mismatches do not overwrite err_addr.
- Back-to-back transfers: the write to A+1 and the readback of A share a cycle. Addresses are distinct because count<=LUT_DEPTH, so no hazard.
- VERIFY: lasts 1 cycle (final compare), with in_ready=0 and wr_en=0. Next state IDLE; done pulses high in the IDLE-entry cycle, concurrent with final error.
- wr_en is never 1 outside LOAD. wr_addr and wr_data hold their last values when wr_en=0.
- abort, in LOAD or VERIFY: next state IDLE, no done pulse, pending verify dropped, error retains its value. abort has priority over a same-cycle transfer: in_ready=0 and wr_en=0 while abort=1. In IDLE, abort is ignored.
- start while busy is ignored.
- Async reset mid-load: all state returns to reset values immediately. lut_ram contents already written are not undone.
- count=LUT_DEPTH with any base_addr writes every entry exactly once, wrapping.

Decomposition:
- lut_ram_pkg holds the loader_state_t enum (IDLE, LOAD, VERIFY) and default LUT_WIDTH/LUT_DEPTH localparams shared with lut_ram.
- One sub-module: lut_ram_loader_check, containing the verify-stage registers, the comparator, and sticky error/err_addr capture.

Test Plan:
- Basic load: base=0x10, count=4, data 0xA0..0xA3, in_valid held high -> wr_en high 4 consecutive cycles at 0x10..0x13; done pulses 1 cycle after the VERIFY state; error=0; mem[0x10..0x13]=0xA0..0xA3.
- Wrap: base=0xFE, count=4 -> writes at 0xFE, 0xFF, 0x00, 0x01; done=1; error=0.
- Backpressure: in_valid toggles 1,0,0,1,1 with count=3 -> exactly 3 writes, only in cycles with in_valid=1; the address sequence is contiguous.
- Fault injection: force lut_ram.mem[0x22]=0 after the write of 0x5A at base=0x20, count=4 -> error=1 and err_addr=0x22 at done; no later overwrite.
- Zero count and ignored start: start with count=0 -> done the next cycle, wr_en never high. A start pulse during LOAD -> no effect on address or remaining.
- Abort and reset: abort after 2 of 8 words -> IDLE, no done, only 2 writes. rst_n low mid-LOAD -> every output reaches its reset value without a clock edge.

Source files
------------

// File: rtl/lut_ram_pkg.sv
// Shared definitions for lut_ram and the blocks that drive it.
//   DEF_LUT_WIDTH / DEF_LUT_DEPTH : default geometry of a lut_ram instance
//   loader_state_t                : lut_ram_loader control states
package lut_ram_pkg;

  localparam int DEF_LUT_WIDTH = 32;
  localparam int DEF_LUT_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY
  } loader_state_t;

endpackage

// File: rtl/lut_ram_loader_check.sv
// Readback stage of lut_ram_loader. It holds the address and data of the most
// recent write for one cycle. During that cycle it presents the address on
// rd_addr and compares the returned rd_data. The first mismatch of a load
// is captured in a sticky flag.
//   clear    : accepted start; clears error/err_addr
//   flush    : abort; drops the pending compare
//   xfer     : a word is being written this cycle (waddr/wdata)
//   rd_addr  : readback address (lut_ram read port)
//   rd_data  : combinational readback data from lut_ram
//   error    : sticky mismatch flag
//   err_addr : address of the first mismatch
module lut_ram_loader_check #(
  parameter int LUT_WIDTH = 32,
  parameter int AW        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 flush,
  input  logic                 xfer,
  input  logic [AW-1:0]        waddr,
  input  logic [LUT_WIDTH-1:0] wdata,
  output logic [AW-1:0]        rd_addr,
  input  logic [LUT_WIDTH-1:0] rd_data,
  output logic                 error,
  output logic [AW-1:0]        err_addr
);

  logic                 vld_q;
  logic [AW-1:0]        vaddr_q;
  logic [LUT_WIDTH-1:0] vdata_q;
  logic                 mismatch;

  // NOTE: the compare registers are plain flops rather than a RAM, so they
  // get a defined reset value; that keeps rd_addr at 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      vaddr_q <= '0;
      vdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // values, so the order of the statements does not matter.
      vld_q <= xfer && !flush;
      if (xfer) begin
        vaddr_q <= waddr;
        vdata_q <= wdata;
      end
    end
  end

  assign rd_addr  = vaddr_q;
  assign mismatch = vld_q && !flush && (rd_data != vdata_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error    <= 1'b0;
      err_addr <= '0;
    end else if (clear) begin
      error    <= 1'b0;
      err_addr <= '0;
    end else if (mismatch && !error) begin
      error    <= 1'b1;
      err_addr <= vaddr_q;
    end
  end

endmodule

// File: rtl/lut_ram_loader.sv
// Writes a valid/ready stream into consecutive lut_ram addresses starting at
// base_addr. The address wraps modulo LUT_DEPTH. Each word is read back on the
// cycle after its write and compared.
//   start/base_addr/count : begin a load (ignored while busy)
//   abort                 : cancel the current load, no done pulse
//   in_valid/in_ready/in_data : input word stream
//   wr_en/wr_addr/wr_data : lut_ram write port
//   rd_addr/rd_data       : lut_ram readback port
//   busy/done/error/err_addr : status
module lut_ram_loader
  import lut_ram_pkg::*;
#(
  parameter  int LUT_WIDTH = DEF_LUT_WIDTH,
  parameter  int LUT_DEPTH = DEF_LUT_DEPTH,
  localparam int AW        = $clog2(LUT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW:0]          count,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LUT_WIDTH-1:0] in_data,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [LUT_WIDTH-1:0] wr_data,
  output logic [AW-1:0]        rd_addr,
  input  logic [LUT_WIDTH-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [AW-1:0]        err_addr
);

  loader_state_t        state_q, state_d;
  logic [AW-1:0]        addr_q;
  logic [AW:0]          remaining;
  logic [AW-1:0]        wr_addr_q;
  logic [LUT_WIDTH-1:0] wr_data_q;
  logic                 done_d;
  logic                 start_ok;

  assign start_ok = (state_q == IDLE) && start;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) done_d  = 1'b1;
          else             state_d = LOAD;
        end
      end
      LOAD: begin
        busy = 1'b1;
        // abort wins over a same-cycle transfer
        if (abort) begin
          state_d = IDLE;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            wr_en = 1'b1;
            if (remaining == (AW+1)'(1)) state_d = VERIFY;
          end
        end
      end
      VERIFY: begin
        busy    = 1'b1;
        state_d = IDLE;
        done_d  = !abort;
      end
      default: state_d = IDLE;
    endcase
  end

  // The write port is a pass-through in the transfer cycle. Otherwise it holds
  // the last written address and data.
  assign wr_addr = wr_en ? addr_q  : wr_addr_q;
  assign wr_data = wr_en ? in_data : wr_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (start_ok && count != '0) begin
        addr_q    <= base_addr;
        remaining <= count;
      end else if (wr_en) begin
        addr_q    <= addr_q + 1'b1;  // wraps modulo LUT_DEPTH
        remaining <= remaining - 1'b1;
      end
      if (wr_en) begin
        wr_addr_q <= addr_q;
        wr_data_q <= in_data;
      end
    end
  end

  lut_ram_loader_check #(
    .LUT_WIDTH (LUT_WIDTH),
    .AW        (AW)
  ) u_check (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .flush    (busy && abort),
    .xfer     (wr_en),
    .waddr    (addr_q),
    .wdata    (in_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .error    (error),
    .err_addr (err_addr)
  );

endmodule

// File: tb/tb_lut_ram_loader.sv
// Self-checking bench for lut_ram_loader with a behavioural lut_ram model.
module tb_lut_ram_loader;

  localparam int LUT_WIDTH = 32;
  localparam int LUT_DEPTH = 256;
  localparam int AW        = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [AW-1:0]        base_addr = '0;
  logic [AW:0]          count = '0;
  logic                 in_valid = 1'b0;
  logic [LUT_WIDTH-1:0] in_data = '0;
  logic                 in_ready, wr_en, busy, done, error;
  logic [AW-1:0]        wr_addr, rd_addr, err_addr;
  logic [LUT_WIDTH-1:0] wr_data, rd_data;

  lut_ram_loader #(.LUT_WIDTH(LUT_WIDTH), .LUT_DEPTH(LUT_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // lut_ram model. Writes landing in [fault_lo, fault_lo+fault_n) store 0
  // instead of the data, which corrupts the entry right after its write.
  logic [LUT_WIDTH-1:0] mem [LUT_DEPTH];
  int fault_lo = 0;
  int fault_n  = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [AW-1:0]        wlog_addr [$];
  logic [LUT_WIDTH-1:0] wlog_data [$];
  int                   wlog_cyc  [$];

  assign rd_data = mem[rd_addr];

  always @(posedge clk) begin
    if (wr_en) begin
      if (((int'(wr_addr) - fault_lo) & 255) < fault_n) mem[wr_addr] <= '0;
      else                                              mem[wr_addr] <= wr_data;
      wlog_addr.push_back(wr_addr);
      wlog_data.push_back(wr_data);
      wlog_cyc.push_back(cyc);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic begin_load(input logic [AW-1:0] b, input int c);
    base_addr = b;
    count     = (AW+1)'(c);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic feed(input int n, input logic [31:0] d0, input logic [7:0] pat, output int sent);
    int k = 0;
    sent = 0;
    while (sent < n && k < 4000) begin
      in_valid = pat[k % 8];
      in_data  = d0 + 32'(sent);
      #1;
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int base_cnt, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt != base_cnt) seen = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0]  base;
    int          cnt;
    logic [31:0] data0;
    logic [7:0]  pat;       // in_valid pattern, bit k drives cycle k%8
    int          fault_lo;
    int          fault_n;
    logic        exp_err;
    logic [7:0]  exp_err_addr;
  } load_vec_t;

  load_vec_t vecs [5];

  initial begin
    int  n0, d0c, sent, bad;
    bit  seen;
    logic [7:0] a;

    vecs[0] = '{8'h10, 4,   32'h0000_00A0, 8'hFF,       0,     0, 1'b0, 8'h00};  // basic
    vecs[1] = '{8'hFE, 4,   32'h0000_00B0, 8'hFF,       0,     0, 1'b0, 8'h00};  // wrap
    vecs[2] = '{8'h05, 3,   32'h0000_00C0, 8'b00011001, 0,     0, 1'b0, 8'h00};  // backpressure 1,0,0,1,1
    vecs[3] = '{8'h20, 4,   32'h0000_0058, 8'hFF,       'h22,  2, 1'b1, 8'h22};  // faults at 0x22 and 0x23
    vecs[4] = '{8'h80, 256, 32'h0000_1000, 8'hFF,       0,     0, 1'b0, 8'h00};  // full depth

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset_ctrl", {in_ready, wr_en, busy, done, error}, 0);
    check("reset_addr", {wr_addr, rd_addr, err_addr}, 0);
    check("reset_data", wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven loads
    for (int v = 0; v < 5; v++) begin
      n0       = wlog_addr.size();
      d0c      = done_cnt;
      fault_lo = vecs[v].fault_lo;
      fault_n  = vecs[v].fault_n;
      begin_load(vecs[v].base, vecs[v].cnt);
      feed(vecs[v].cnt, vecs[v].data0, vecs[v].pat, sent);
      wait_done(d0c, seen);
      check($sformatf("v%0d_done_seen", v), 32'(seen), 1);
      repeat (3) @(negedge clk);
      fault_n = 0;
      check($sformatf("v%0d_writes", v), wlog_addr.size() - n0, vecs[v].cnt);
      bad = 0;
      for (int i = 0; i < vecs[v].cnt; i++) begin
        a = vecs[v].base + 8'(i);
        if (n0 + i >= wlog_addr.size()) bad++;
        else if (wlog_addr[n0+i] !== a || wlog_data[n0+i] !== vecs[v].data0 + 32'(i)) bad++;
        if (((int'(a) - vecs[v].fault_lo) & 255) >= vecs[v].fault_n &&
            mem[a] !== vecs[v].data0 + 32'(i)) bad++;
      end
      check($sformatf("v%0d_addr_data_mem", v), bad, 0);
      if (wlog_addr.size() - n0 == vecs[v].cnt) begin
        if (vecs[v].pat == 8'hFF)
          check($sformatf("v%0d_consecutive", v), wlog_cyc[n0+vecs[v].cnt-1] - wlog_cyc[n0], vecs[v].cnt - 1);
        check($sformatf("v%0d_done_lag", v), done_cyc - wlog_cyc[n0+vecs[v].cnt-1], 2);
      end
      check($sformatf("v%0d_done_once", v), done_cnt - d0c, 1);
      check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_err_addr", v), 32'(err_addr), 32'(vecs[v].exp_err_addr));
      check($sformatf("v%0d_idle", v), {busy, in_ready, wr_en}, 0);
    end

    // A start pulse during LOAD changes neither address nor length
    n0  = wlog_addr.size();
    d0c = done_cnt;
    begin_load(8'h40, 3);
    in_valid = 1'b1;
    in_data  = 32'h400;
    @(negedge clk);
    start     = 1'b1;
    base_addr = 8'h80;
    count     = 9'd5;
    in_data   = 32'h401;
    @(negedge clk);
    start   = 1'b0;
    in_data = 32'h402;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(d0c, seen);
    repeat (3) @(negedge clk);
    check("ign_start_writes", wlog_addr.size() - n0, 3);
    if (wlog_addr.size() - n0 == 3)
      check("ign_start_addrs", {wlog_addr[n0], wlog_addr[n0+1], wlog_addr[n0+2]}, 24'h404142);
    check("ign_start_done", done_cnt - d0c, 1);

    // Zero-length load: done the next cycle, no writes
    n0 = wlog_addr.size();
    begin_load(8'h77, 0);
    check("zero_done", {done, busy}, 2'b10);
    @(negedge clk);
    check("zero_done_pulse", 32'(done), 0);
    check("zero_no_write", wlog_addr.size() - n0, 0);

    // Abort after 2 of 8 words
    n0  = wlog_addr.size();
    d0c = done_cnt;
    begin_load(8'h60, 8);
    feed(2, 32'h600, 8'hFF, sent);
    abort    = 1'b1;
    in_valid = 1'b1;
    #1;
    check("abort_blocks", {busy, in_ready, wr_en}, 3'b100);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_writes", wlog_addr.size() - n0, 2);
    check("abort_no_done", done_cnt - d0c, 0);
    check("abort_idle", 32'(busy), 0);

    // Asynchronous reset mid-load with a mismatch already flagged
    fault_lo = 'h30;
    fault_n  = 1;
    begin_load(8'h30, 8);
    in_valid = 1'b1;
    in_data  = 32'h700;
    @(negedge clk);
    in_data = 32'h701;
    @(negedge clk);
    fault_n = 0;
    check("pre_reset", {busy, error, err_addr}, {1'b1, 1'b1, 8'h30});
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctrl", {in_ready, wr_en, busy, done, error}, 0);
    check("rst_addr", {wr_addr, rd_addr, err_addr}, 0);
    check("rst_data", wr_data, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
